led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Multi-channel LED pattern generator. Parametrised successor to the single-LED fixed-rate blinker.
- Each of NUM_LEDS channels is configured at runtime through a valid/ready write port. Modes: OFF, ON, BLINK with a programmable half-period, or BURST of N blinks followed by auto-off.
- A shared prescaler produces the time base. Sits between the board-control logic and the LED pins.

Parameters:
- CLK_FREQ, 25_000_000, input clock frequency in Hz.
- TICK_HZ, 1000, time-base tick rate; TICK_DIV = CLK_FREQ/TICK_HZ, minimum 1.
- NUM_LEDS, 8, number of channels (1..16).
- PER_W, 16, width of the half-period field, in ticks.
- CNT_W, 8, width of the burst-count field.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config port can accept
- cfg_chan  in  4  target channel index
- cfg_mode  in  2  0=OFF 1=ON 2=BLINK 3=BURST
- cfg_period  in  PER_W  half-period in ticks (0 treated as 1)
- cfg_count  in  CNT_W  burst blink count
- leds  out  NUM_LEDS  LED drive, 1=lit
- tick  out  1  one-cycle time-base pulse, for debug and verification

Behaviour:
- Reset (rst=1 at posedge):
  - prescaler=0, tick=0, leds=0, cfg_ready=1.
  - All channels: mode=OFF, counter=0, burst remaining=0.
  - Reset mid-burst or mid-blink aborts immediately; leds=0 on the next cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the cycle where the count equals TICK_DIV-1. Period is exactly TICK_DIV cycles.
  - TICK_DIV=1 gives tick=1 every cycle.
- Handshake:
  - Accept occurs on a posedge with cfg_valid&cfg_ready. Inputs are sampled on that edge.
  - cfg_ready goes 0 for exactly the next cycle, then returns to 1. Throughput is at most one write per 2 cycles.
  - cfg_valid while cfg_ready=0 is ignored. The master must hold its inputs.
  - cfg_chan>=NUM_LEDS: write is acknowledged (normal ready behaviour) but has no effect.
- Apply (registered, on the accept edge; visible on leds the following cycle):
  - OFF: led=0.
  - ON: led=1.
  - BLINK: led=1, counter=0, period latched.
  - BURST: led=1, counter=0, period latched, remaining=cfg_count. If cfg_count=0, behaves as OFF (led=0, mode=OFF).
  - Rewriting an active channel restarts it from phase 0.
- Channel timing (applies on tick cycles only; BLINK and BURST):
  - If counter >= P-1: counter=0 and led toggles.
  - Otherwise counter increments.
  - One full cycle is 2*P ticks. The lit phase starts at apply.
- BURST completion:
  - On each toggle 1->0, remaining decrements.
  - When remaining reaches 0, mode becomes OFF and led stays 0.
  - Total lit phases equal cfg_count.
- Simultaneous events:
  - Accept and tick on the same cycle for the same channel: config wins and that tick is discarded for that channel. Other channels process the tick normally.
- Arithmetic:
  - Counters are PER_W wide, compare-and-clear. Never wraps by overflow.
  - P=0 is coerced to 1.
- Channels are independent. No cross-channel phase coupling.

Optional Feature:
- Macro: LED_PATTERN_DONE_EN.
- When defined:
  - Adds output burst_done [NUM_LEDS], reset 0.
  - Bit i pulses 1 for one cycle, coincident with the cycle in which channel i's led first shows 0 after its final burst lit phase.
  - No pulse for cfg_count=0 or for a burst aborted by rewrite or reset.
- When undefined: port absent. All other behaviour is identical.

Test Plan:
- Bench parameters: CLK_FREQ=100, TICK_HZ=10 (TICK_DIV=10), NUM_LEDS=4.
- Reset: hold rst 3 cycles -> leds=0000, cfg_ready=1; after release, tick pulses at cycles 10, 20, 30 counted from the first non-reset edge.
- BLINK: ch1, period=2 -> leds[1]=1 for 2 ticks (20 cycles), then 0 for 20, repeating; other bits stay 0.
- Handshake: cfg_valid held high for 4 cycles with different data -> exactly 2 writes accepted (cycles 0 and 2); cfg_ready pattern 1,0,1,0.
- BURST: ch2, period=1, count=3 -> exactly 3 lit phases of 10 cycles each, then leds[2]=0 permanently; with LED_PATTERN_DONE_EN defined, burst_done[2] gives one pulse at the final falling edge.
- Edge cases:
  - cfg_chan=7 -> ack, leds unchanged.
  - BURST with count=0 -> led stays 0.
  - period=0 -> behaves as period=1.
  - Write on a tick cycle -> counter restarts from 0.
- Reset mid-BURST (after 1 lit phase) -> leds=0 on the next cycle; no burst_done pulse; channel remains OFF after release.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel OFF/ON/BLINK/BURST LED driver on a shared tick prescaler
// Define LED_PATTERN_DONE_EN to add the per-channel burst_done pulse output.
module led_pattern_gen #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int NUM_LEDS = 8,
    parameter int PER_W    = 16,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PER_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_count,
    output logic [NUM_LEDS-1:0] leds,
`ifdef LED_PATTERN_DONE_EN
    output logic [NUM_LEDS-1:0] burst_done,
`endif
    output logic                tick
);
    localparam int TICK_DIV = (CLK_FREQ / TICK_HZ < 1) ? 1 : CLK_FREQ / TICK_HZ;
    localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {OFF, ON, BLINK, BURST} mode_t;

    logic [PS_W-1:0]     ps;
    logic                accept, off_w;
    logic [PER_W-1:0]    per_in;
    mode_t               mode[NUM_LEDS], mode_n[NUM_LEDS];
    logic [PER_W-1:0]    cnt[NUM_LEDS], cnt_n[NUM_LEDS], per[NUM_LEDS], per_n[NUM_LEDS];
    logic [CNT_W-1:0]    rem[NUM_LEDS], rem_n[NUM_LEDS];
    logic [NUM_LEDS-1:0] led, led_n;
`ifdef LED_PATTERN_DONE_EN
    logic [NUM_LEDS-1:0] done_n;
`endif

    assign tick   = (ps == PS_W'(TICK_DIV - 1)) && !rst;
    assign accept = cfg_valid && cfg_ready;
    assign leds   = led;
    assign per_in = (cfg_period == '0) ? PER_W'(1) : cfg_period;
    // a zero-length burst is just an OFF write
    assign off_w  = (cfg_mode == 2'd0) || (cfg_mode == 2'd3 && cfg_count == '0);

    always_comb begin
        led_n = led;
`ifdef LED_PATTERN_DONE_EN
        done_n = '0;
`endif
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode_n[i] = mode[i];
            cnt_n[i]  = cnt[i];
            per_n[i]  = per[i];
            rem_n[i]  = rem[i];
            if (accept && cfg_chan == 4'(i)) begin
                mode_n[i] = off_w ? OFF : mode_t'(cfg_mode);
                led_n[i]  = !off_w;
                cnt_n[i]  = '0;
                per_n[i]  = per_in;
                rem_n[i]  = cfg_count;
            end else if (tick && (mode[i] == BLINK || mode[i] == BURST)) begin
                if (cnt[i] >= per[i] - 1'b1) begin
                    cnt_n[i] = '0;
                    led_n[i] = !led[i];
                    if (mode[i] == BURST && led[i]) begin
                        rem_n[i] = rem[i] - 1'b1;
                        if (rem[i] == CNT_W'(1)) begin
                            mode_n[i] = OFF;
`ifdef LED_PATTERN_DONE_EN
                            done_n[i] = 1'b1;
`endif
                        end
                    end
                end else begin
                    cnt_n[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps        <= '0;
            cfg_ready <= 1'b1;
            led       <= '0;
`ifdef LED_PATTERN_DONE_EN
            burst_done <= '0;
`endif
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode[i] <= OFF;
                cnt[i]  <= '0;
                per[i]  <= '0;
                rem[i]  <= '0;
            end
        end else begin
            ps        <= tick ? '0 : ps + 1'b1;
            cfg_ready <= !accept;
            led       <= led_n;
`ifdef LED_PATTERN_DONE_EN
            burst_done <= done_n;
`endif
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode[i] <= mode_n[i];
                cnt[i]  <= cnt_n[i];
                per[i]  <= per_n[i];
                rem[i]  <= rem_n[i];
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed checks of led_pattern_gen with TICK_DIV=10, 4 channels
// Build with LED_PATTERN_DONE_EN to also check burst_done.
module tb_led_pattern_gen;
    logic        clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_ready, tick;
    logic [3:0]  cfg_chan = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_period = '0;
    logic [7:0]  cfg_count = '0;
    logic [3:0]  leds;
`ifdef LED_PATTERN_DONE_EN
    logic [3:0]  burst_done;
`endif
    int n = 0, nvec = 0, nerr = 0;

    led_pattern_gen #(.CLK_FREQ(100), .TICK_HZ(10), .NUM_LEDS(4)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_count(cfg_count), .leds(leds),
`ifdef LED_PATTERN_DONE_EN
        .burst_done(burst_done),
`endif
        .tick(tick)
    );

    always #5 clk = !clk;

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] ch, input logic [1:0] m, input logic [15:0] p, input logic [7:0] c);
        cfg_chan = ch; cfg_mode = m; cfg_period = p; cfg_count = c;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic chk_done(input logic [3:0] exp);
`ifdef LED_PATTERN_DONE_EN
        chk("burst_done", burst_done, exp);
`else
        if (exp !== 4'b0000) $display("note: burst_done not built");
`endif
    endtask

    initial begin
        repeat (3) step();
        chk("rst_leds", leds, 4'b0000);
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_tick", tick, 1'b0);
        chk_done(4'b0000);
        rst = 1'b0;
        n = 0;
        // prescaler: count k after the k-th edge, tick while count is 9
        while (n < 30) begin
            step();
            chk("tick", tick, n % 10 == 9);
        end
        // BLINK ch1 P=2 accepted on the tick edge 40
        while (n < 39) step();
        wr(4'd1, 2'd2, 16'd2, 8'd0);
        chk("blink_ready", cfg_ready, 1'b0);
        chk("blink", leds, 4'b0010);
        while (n < 100) begin
            step();
            chk("blink", leds, (((n - 40) / 20) % 2 == 0) ? 4'b0010 : 4'b0000);
        end
        // four held cycles: A(ch0 ON) B(ch0 OFF) C(ch3 ON) D(ch3 OFF); only A and C land
        cfg_valid = 1'b1; cfg_chan = 4'd0; cfg_mode = 2'd1;
        chk("hs_ready0", cfg_ready, 1'b1);
        step(); cfg_mode = 2'd0;
        chk("hs_ready1", cfg_ready, 1'b0);
        step(); cfg_chan = 4'd3; cfg_mode = 2'd1;
        chk("hs_ready2", cfg_ready, 1'b1);
        step(); cfg_mode = 2'd0;
        chk("hs_ready3", cfg_ready, 1'b0);
        step(); cfg_valid = 1'b0;
        chk("hs_leds", leds, 4'b1001);
        chk("hs_ready4", cfg_ready, 1'b1);
        // out-of-range channel with OFF must not alias onto ch3
        wr(4'd7, 2'd0, 16'd1, 8'd0);
        chk("oor_ack", cfg_ready, 1'b0);
        chk("oor_leds", leds, 4'b1001);
        step(); wr(4'd0, 2'd0, 16'd1, 8'd0);
        step(); wr(4'd3, 2'd0, 16'd1, 8'd0);
        step(); wr(4'd1, 2'd0, 16'd1, 8'd0);
        chk("all_off", leds, 4'b0000);
        // BURST ch2 P=1 count=3 from tick edge 120: lit 120,140,160; off from 170
        while (n < 119) step();
        wr(4'd2, 2'd3, 16'd1, 8'd3);
        chk("burst", leds, 4'b0100);
        chk_done(4'b0000);
        while (n < 200) begin
            step();
            chk("burst", leds, (n < 170 && ((n - 120) / 10) % 2 == 0) ? 4'b0100 : 4'b0000);
            chk_done(n == 170 ? 4'b0100 : 4'b0000);
        end
        wr(4'd2, 2'd3, 16'd1, 8'd0);
        chk("cnt0_ack", cfg_ready, 1'b0);
        while (n < 215) begin
            step();
            chk("cnt0", leds, 4'b0000);
            chk_done(4'b0000);
        end
        // period 0 acts as 1, started on tick edge 220
        while (n < 219) step();
        wr(4'd0, 2'd2, 16'd0, 8'd0);
        chk("per0", leds, 4'b0001);
        while (n < 249) begin
            step();
            chk("per0", leds, (((n - 220) / 10) % 2 == 0) ? 4'b0001 : 4'b0000);
        end
        // rewrite on tick edge 250 where ch0 would have gone dark; the tick is dropped
        wr(4'd0, 2'd2, 16'd2, 8'd0);
        chk("retick", leds, 4'b0001);
        while (n < 289) begin
            step();
            chk("retick", leds, n < 270 ? 4'b0001 : 4'b0000);
        end
        wr(4'd0, 2'd0, 16'd1, 8'd0);
        chk("ch0_off", leds, 4'b0000);
        // reset in the second lit phase of a burst
        while (n < 299) step();
        wr(4'd2, 2'd3, 16'd1, 8'd3);
        while (n < 324) begin
            step();
            chk("burst2", leds, (((n - 300) / 10) % 2 == 0) ? 4'b0100 : 4'b0000);
        end
        rst = 1'b1;
        step();
        chk("mid_rst_leds", leds, 4'b0000);
        chk("mid_rst_ready", cfg_ready, 1'b1);
        chk("mid_rst_tick", tick, 1'b0);
        chk_done(4'b0000);
        step();
        rst = 1'b0;
        repeat (40) begin
            step();
            chk("post_rst", leds, 4'b0000);
            chk_done(4'b0000);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
